// File: rtl/ircam_pkg.sv
// Shared constants and types for the camera ping-pong write path.
package ircam_pkg;

    localparam int unsigned FRAME_W = 32;
    localparam int unsigned FRAME_H = 24;
    localparam int unsigned PIX_N   = FRAME_W * FRAME_H;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        WRITE,
        DROP
    } wr_state_t;

endpackage

// File: rtl/pingpong_frame_ctrl_if.sv
// Camera-side, SRAM write-side and reader-status signals of the ping-pong controller.
interface pingpong_frame_ctrl_if;
    import ircam_pkg::*;

    logic              en;
    logic              i_sof;
    logic [DATA_W-1:0] i_data;
    logic              i_data_vld;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_done_tgl;
    logic              rd_bank_vld;
    logic              rd_bank;
    logic              frame_drop;
    logic              short_frame;
    logic [7:0]        drop_cnt;

    // Source of camera pixels and reader toggle; sink of strobes and status.
    modport master (
        output en, i_sof, i_data, i_data_vld, rd_done_tgl,
        input  wr_en, wr_bank, wr_addr, wr_data, rd_bank_vld, rd_bank,
        input  frame_drop, short_frame, drop_cnt
    );

    // The controller itself.
    modport slave (
        input  en, i_sof, i_data, i_data_vld, rd_done_tgl,
        output wr_en, wr_bank, wr_addr, wr_data, rd_bank_vld, rd_bank,
        output frame_drop, short_frame, drop_cnt
    );

endinterface

// File: rtl/toggle_sync.sv
// Two-flop synchroniser for a level toggle, followed by an edge detector that emits
// a one-cycle pulse per toggle.
module toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl,
    output logic pulse
);

    logic [2:0] sync_q;

    // [0],[1] form the synchroniser, [2] holds the previous synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], tgl};
        end
    end

    assign pulse = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/pingpong_frame_ctrl.sv
// Write-side scheduler for the two-bank camera ping-pong SRAM. Turns camera pixels into
// bank write strobes, tracks which banks hold complete frames, and hands them to the reader.
module pingpong_frame_ctrl (
    input logic                  rst_n,
    input logic                  din_clk,
    pingpong_frame_ctrl_if.slave bus
);
    import ircam_pkg::*;

    wr_state_t         state_q;
    logic [ADDR_W-1:0] pix_cnt_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic              wr_sel_q;
    logic              rd_sel_q;
    logic              rd_sel_d;
    logic [7:0]        drop_cnt_q;

    logic              wr_en_q;
    logic              wr_bank_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              rd_bank_vld_q;
    logic              rd_bank_q;
    logic              frame_drop_q;
    logic              short_frame_q;

    logic              rd_done;
    logic              start_ok;
    logic              take_pix;
    logic              last_pix;
    logic              release_bank;
    logic [ADDR_W-1:0] addr_nxt;

    toggle_sync u_rd_done_sync (
        .clk   (din_clk),
        .rst_n (rst_n),
        .tgl   (bus.rd_done_tgl),
        .pulse (rd_done)
    );

    // Pixel acceptance and bank bookkeeping; commit and release may land together
    // because a commit never targets a full bank.
    always_comb begin
        addr_nxt     = bus.i_sof ? '0 : pix_cnt_q;
        start_ok     = bus.en && bus.i_sof && !full_q[wr_sel_q] &&
                       ((state_q == WAIT_SOF) || (state_q == DROP));
        take_pix     = bus.en && bus.i_data_vld && ((state_q == WRITE) || start_ok);
        last_pix     = take_pix && (addr_nxt == ADDR_W'(PIX_N - 1));
        release_bank = rd_done && full_q[rd_sel_q];
        full_d       = full_q;
        if (last_pix) begin
            full_d[wr_sel_q] = 1'b1;
        end
        if (release_bank) begin
            full_d[rd_sel_q] = 1'b0;
        end
        rd_sel_d     = rd_sel_q ^ release_bank;
    end

    // Frame FSM with pixel counter, write port and event pulses.
    always_ff @(posedge din_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pix_cnt_q     <= '0;
            wr_sel_q      <= 1'b0;
            drop_cnt_q    <= 8'd0;
            wr_en_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_drop_q  <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            wr_en_q       <= take_pix;
            frame_drop_q  <= 1'b0;
            short_frame_q <= 1'b0;
            if (take_pix) begin
                wr_bank_q <= wr_sel_q;
                wr_addr_q <= addr_nxt;
                wr_data_q <= bus.i_data;
            end
            if (!bus.en) begin
                // Abort: partially written bank stays non-full and is rewritten later.
                state_q       <= IDLE;
                pix_cnt_q     <= '0;
                short_frame_q <= (state_q == WRITE);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= WAIT_SOF;
                    end
                    WAIT_SOF, DROP: begin
                        if (bus.i_sof) begin
                            if (full_q[wr_sel_q]) begin
                                state_q      <= DROP;
                                frame_drop_q <= 1'b1;
                                if (drop_cnt_q != 8'hFF) begin
                                    drop_cnt_q <= drop_cnt_q + 8'd1;
                                end
                            end else begin
                                state_q   <= WRITE;
                                pix_cnt_q <= take_pix ? ADDR_W'(1) : '0;
                            end
                        end
                    end
                    WRITE: begin
                        if (bus.i_sof) begin
                            short_frame_q <= 1'b1;
                        end
                        if (last_pix) begin
                            state_q   <= WAIT_SOF;
                            wr_sel_q  <= ~wr_sel_q;
                            pix_cnt_q <= '0;
                        end else if (take_pix) begin
                            pix_cnt_q <= addr_nxt + ADDR_W'(1);
                        end else begin
                            pix_cnt_q <= addr_nxt;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Bank status and reader-facing view of it.
    always_ff @(posedge din_clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q        <= 2'b00;
            rd_sel_q      <= 1'b0;
            rd_bank_vld_q <= 1'b0;
            rd_bank_q     <= 1'b0;
        end else begin
            full_q        <= full_d;
            rd_sel_q      <= rd_sel_d;
            rd_bank_vld_q <= full_d[rd_sel_d];
            rd_bank_q     <= rd_sel_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_bank     = wr_bank_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_bank_vld = rd_bank_vld_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.frame_drop  = frame_drop_q;
    assign bus.short_frame = short_frame_q;
    assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// Randomised bench for pingpong_frame_ctrl against a frame-level reference model.
module tb_pingpong_frame_ctrl;
    import ircam_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pingpong_frame_ctrl_if bus ();

    pingpong_frame_ctrl dut (
        .rst_n   (rst_n),
        .din_clk (clk),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;

    // Reference model: bank ownership, frame progress, and expected outputs.
    bit       m_armed;
    bit       m_in_frame;
    int       m_pix;
    bit [1:0] m_full;
    bit       m_wr_sel;
    bit       m_rd_sel;
    int       m_drop_cnt;
    bit [3:0] m_tgl_hist;

    logic              e_wr_en;
    logic              e_bank;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_drop;
    logic              e_short;
    logic              e_rd_vld;
    logic              e_rd_bank;
    logic [7:0]        e_drop_cnt;

    task automatic model_reset();
        m_armed = 0; m_in_frame = 0; m_pix = 0; m_full = 2'b00;
        m_wr_sel = 0; m_rd_sel = 0; m_drop_cnt = 0; m_tgl_hist = 4'b0000;
        e_wr_en = 0; e_bank = 0; e_addr = '0; e_data = '0; e_drop = 0; e_short = 0;
        e_rd_vld = 0; e_rd_bank = 0; e_drop_cnt = 8'd0;
    endtask

    task automatic model_edge(input bit en, input bit sof, input bit vld,
                              input logic [7:0] d, input bit tgl);
        bit done;
        bit commit;
        e_wr_en = 0; e_drop = 0; e_short = 0; commit = 0;
        // The reader's toggle takes effect three clock edges after it changes.
        m_tgl_hist = {m_tgl_hist[2:0], tgl};
        done = m_tgl_hist[2] ^ m_tgl_hist[3];
        if (!en) begin
            if (m_in_frame) e_short = 1;
            m_in_frame = 0; m_armed = 0; m_pix = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else begin
            if (sof) begin
                if (m_in_frame) begin
                    e_short = 1; m_pix = 0;
                end else if (m_full[m_wr_sel]) begin
                    e_drop = 1;
                    if (m_drop_cnt < 255) m_drop_cnt++;
                end else begin
                    m_in_frame = 1; m_pix = 0;
                end
            end
            if (m_in_frame && vld) begin
                e_wr_en = 1; e_bank = m_wr_sel; e_addr = ADDR_W'(m_pix); e_data = d;
                if (m_pix == int'(PIX_N) - 1) begin
                    commit = 1; m_in_frame = 0; m_pix = 0;
                end else begin
                    m_pix++;
                end
            end
        end
        if (done && m_full[m_rd_sel]) begin
            m_full[m_rd_sel] = 0;
            m_rd_sel = ~m_rd_sel;
        end
        if (commit) begin
            m_full[m_wr_sel] = 1;
            m_wr_sel = ~m_wr_sel;
        end
        e_rd_vld = m_full[m_rd_sel];
        e_rd_bank = m_rd_sel;
        e_drop_cnt = 8'(m_drop_cnt);
    endtask

    // Drive one clock's worth of camera inputs, advance the model, land on the negedge.
    task automatic cyc(input bit en, input bit sof, input bit vld, input logic [7:0] d);
        bus.en = en; bus.i_sof = sof; bus.i_data_vld = vld; bus.i_data = d;
        @(posedge clk);
        model_edge(en, sof, vld, d, bus.rd_done_tgl);
        @(negedge clk);
        if (bus.wr_en === 1'b1) n_wr++;
    endtask

    task automatic hold_reset();
        bus.en = 0; bus.i_sof = 0; bus.i_data_vld = 0; bus.i_data = '0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Send n valid pixels (optionally opened by i_sof), checking every cycle.
    task automatic drive_pixels(input int n, input bit sof_first, input bit gaps,
                                input bit rnd, input int tgl_at);
        int sent;
        bit first;
        bit v;
        logic [7:0] d;
        sent = 0;
        first = sof_first;
        while (sent < n) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = rnd ? 8'($urandom) : (first ? 8'd0 : 8'(m_pix));
            if (tgl_at >= 0 && m_in_frame && v && m_pix == tgl_at) begin
                bus.rd_done_tgl = ~bus.rd_done_tgl;
            end
            cyc(1'b1, first, v, d);
            first = 0;
            if (v) sent++;
            n_cmp++;
            if (bus.wr_en !== e_wr_en || (e_wr_en && (bus.wr_bank !== e_bank ||
                bus.wr_addr !== e_addr || bus.wr_data !== e_data))) begin
                n_bad++;
                $display("FAIL write_port: got en=%b bank=%b addr=%0d data=%h, want en=%b bank=%b addr=%0d data=%h",
                         bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data,
                         e_wr_en, e_bank, e_addr, e_data);
            end
            n_cmp++;
            if ({bus.rd_bank_vld, bus.rd_bank, bus.frame_drop, bus.short_frame, bus.drop_cnt} !==
                {e_rd_vld, e_rd_bank, e_drop, e_short, e_drop_cnt}) begin
                n_bad++;
                $display("FAIL status: got vld=%b bank=%b drop=%b short=%b cnt=%0d, want vld=%b bank=%b drop=%b short=%b cnt=%0d",
                         bus.rd_bank_vld, bus.rd_bank, bus.frame_drop, bus.short_frame,
                         bus.drop_cnt, e_rd_vld, e_rd_bank, e_drop, e_short, e_drop_cnt);
            end
        end
    endtask

    task automatic test_reset();
        bus.rd_done_tgl = 0;
        hold_reset();
        n_cmp++;
        if ({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data, bus.rd_bank_vld, bus.rd_bank,
             bus.frame_drop, bus.short_frame, bus.drop_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%0d vld=%b cnt=%0d, want all zero",
                     bus.wr_en, bus.wr_addr, bus.rd_bank_vld, bus.drop_cnt);
        end
    endtask

    task automatic test_single_frame();
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b1, 1'b0, 8'd0);
        n_wr = 0;
        drive_pixels(PIX_N, 1'b0, 1'b1, 1'b0, -1);
        n_cmp++;
        if (n_wr != int'(PIX_N)) begin
            n_bad++;
            $display("FAIL frame1_write_count: got %0d, want %0d", n_wr, PIX_N);
        end
        n_cmp++;
        if (bus.rd_bank_vld !== 1'b1 || bus.rd_bank !== 1'b0) begin
            n_bad++;
            $display("FAIL frame1_ready: got vld=%b bank=%b, want vld=1 bank=0",
                     bus.rd_bank_vld, bus.rd_bank);
        end
    endtask

    task automatic test_drop();
        drive_pixels(PIX_N, 1'b1, 1'b1, 1'b1, -1);
        cyc(1'b1, 1'b1, 1'b1, 8'h5A);
        n_cmp++;
        if (bus.frame_drop !== 1'b1 || bus.drop_cnt !== 8'd1 || bus.wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL first_drop: got drop=%b cnt=%0d wr_en=%b, want drop=1 cnt=1 wr_en=0",
                     bus.frame_drop, bus.drop_cnt, bus.wr_en);
        end
        // Hammer i_sof until the counter saturates; frames keep being discarded.
        drive_pixels(3, 1'b0, 1'b1, 1'b1, -1);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            n_cmp++;
            if ({bus.wr_en, bus.frame_drop, bus.drop_cnt} !== {e_wr_en, e_drop, e_drop_cnt}) begin
                n_bad++;
                $display("FAIL drop_loop: got wr_en=%b drop=%b cnt=%0d, want wr_en=%b drop=%b cnt=%0d",
                         bus.wr_en, bus.frame_drop, bus.drop_cnt, e_wr_en, e_drop, e_drop_cnt);
            end
        end
        n_cmp++;
        if (bus.drop_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL drop_saturate: got %0d, want 255", bus.drop_cnt);
        end
    endtask

    task automatic test_release();
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        bus.rd_done_tgl = ~bus.rd_done_tgl;
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        n_cmp++;
        if (bus.rd_bank !== 1'b0 || bus.rd_bank_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL release_early: got bank=%b vld=%b, want bank=0 vld=1",
                     bus.rd_bank, bus.rd_bank_vld);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        n_cmp++;
        if (bus.rd_bank !== 1'b1 || bus.rd_bank_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL release_3cyc: got bank=%b vld=%b, want bank=1 vld=1",
                     bus.rd_bank, bus.rd_bank_vld);
        end
        drive_pixels(PIX_N, 1'b1, 1'b1, 1'b1, -1);
    endtask

    task automatic test_commit_release();
        bus.rd_done_tgl = ~bus.rd_done_tgl;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'd0);
        n_cmp++;
        if (bus.rd_bank !== 1'b0 || bus.rd_bank_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_coincide: got bank=%b vld=%b, want bank=0 vld=1",
                     bus.rd_bank, bus.rd_bank_vld);
        end
        // Toggle lands so that bank 0's release hits the edge that commits bank 1.
        drive_pixels(PIX_N, 1'b1, 1'b0, 1'b1, int'(PIX_N) - 3);
        n_cmp++;
        if (bus.rd_bank !== 1'b1 || bus.rd_bank_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL coincide: got bank=%b vld=%b, want bank=1 vld=1",
                     bus.rd_bank, bus.rd_bank_vld);
        end
        cyc(1'b1, 1'b1, 1'b1, 8'hC3);
        n_cmp++;
        if (bus.wr_en !== 1'b1 || bus.wr_bank !== 1'b0 || bus.wr_addr !== '0) begin
            n_bad++;
            $display("FAIL next_bank0: got en=%b bank=%b addr=%0d, want en=1 bank=0 addr=0",
                     bus.wr_en, bus.wr_bank, bus.wr_addr);
        end
        drive_pixels(20, 1'b0, 1'b1, 1'b1, -1);
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        n_cmp++;
        if (bus.short_frame !== 1'b1 || bus.wr_en !== 1'b0 || bus.rd_bank_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL en_abort: got short=%b wr_en=%b vld=%b, want short=1 wr_en=0 vld=1",
                     bus.short_frame, bus.wr_en, bus.rd_bank_vld);
        end
    endtask

    task automatic test_short_frame();
        hold_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        drive_pixels(100, 1'b1, 1'b1, 1'b0, -1);
        cyc(1'b1, 1'b1, 1'b1, 8'h00);
        n_cmp++;
        if (bus.short_frame !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_addr !== '0 ||
            bus.wr_bank !== 1'b0 || bus.rd_bank_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL short_restart: got short=%b en=%b addr=%0d bank=%b vld=%b, want 1 1 0 0 0",
                     bus.short_frame, bus.wr_en, bus.wr_addr, bus.wr_bank, bus.rd_bank_vld);
        end
        drive_pixels(PIX_N - 1, 1'b0, 1'b1, 1'b0, -1);
        n_cmp++;
        if (bus.rd_bank_vld !== 1'b1 || bus.rd_bank !== 1'b0) begin
            n_bad++;
            $display("FAIL short_then_full: got vld=%b bank=%b, want vld=1 bank=0",
                     bus.rd_bank_vld, bus.rd_bank);
        end
        drive_pixels(30, 1'b1, 1'b1, 1'b1, -1);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        n_cmp++;
        if (bus.short_frame !== e_short || bus.rd_bank_vld !== e_rd_vld) begin
            n_bad++;
            $display("FAIL short_en_low: got short=%b vld=%b, want short=%b vld=%b",
                     bus.short_frame, bus.rd_bank_vld, e_short, e_rd_vld);
        end
    endtask

    task automatic test_reset_mid_write();
        hold_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        drive_pixels(300, 1'b1, 1'b1, 1'b1, -1);
        rst_n = 0;
        #1;
        n_cmp++;
        if ({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data, bus.rd_bank_vld, bus.rd_bank,
             bus.frame_drop, bus.short_frame, bus.drop_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_write: got wr_en=%b addr=%0d data=%h, want all zero",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        drive_pixels(PIX_N, 1'b1, 1'b1, 1'b1, -1);
        n_cmp++;
        if (bus.rd_bank_vld !== 1'b1 || bus.rd_bank !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_bank0: got vld=%b bank=%b, want vld=1 bank=0",
                     bus.rd_bank_vld, bus.rd_bank);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_drop();
        test_release();
        test_commit_release();
        test_short_frame();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
